// File: rtl/mem_config_pkg.sv
// Image memory geometry shared by the memory and its readers.
package mem_config_pkg;

   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned DATA_WIDTH = 8;

endpackage

// File: rtl/sobel_config_pkg.sv
// Sobel pipeline configuration: image size, pixel/window types and fetch FSM states.
package sobel_config_pkg;

   import mem_config_pkg::*;

   localparam int unsigned IMG_W = 256;
   localparam int unsigned IMG_H = 256;

   typedef logic [DATA_WIDTH-1:0] pixel_t;

   // [row][col], row 0 is the top line, col 0 the left column
   typedef pixel_t [2:0][2:0] window_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: simple dual-port RAM with a registered read port.
module line_buffer
   import mem_config_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = DATA_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]         rd_data_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // write port plus one-cycle registered read; read-during-write returns old data
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         r_mem[wr_addr_i] <= wr_data_i;
      end
      r_rd_data <= r_mem[rd_addr_i];
   end

   assign rd_data_o = r_rd_data;

endmodule

// File: rtl/mem_window_fetch.sv
// Raster-order image fetch that streams every interior 3x3 neighbourhood
// through a 2-entry output FIFO with read credits.
// Optional macro FETCH_PERF_EN adds the stall_cycles_o back-pressure counter.
module mem_window_fetch #(
   parameter int unsigned IMG_W      = sobel_config_pkg::IMG_W,
   parameter int unsigned IMG_H      = sobel_config_pkg::IMG_H,
   parameter int unsigned ADDR_WIDTH = mem_config_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = mem_config_pkg::DATA_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data_i,
   output logic                    win_valid_o,
   input  logic                    win_ready_i,
   output logic [9*DATA_WIDTH-1:0] win_o,
   output logic [15:0]             win_row_o,
`ifdef FETCH_PERF_EN
   output logic [31:0]             stall_cycles_o,
`endif
   output logic [15:0]             win_col_o
);

   import sobel_config_pkg::*;

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned WW = 9 * DATA_WIDTH;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef struct packed {
      logic [WW-1:0] win;
      logic [15:0]   row;
      logic [15:0]   col;
   } fifo_entry_t;

   fetch_state_e r_state, w_state_nxt;

   // raster position of the next read to issue
   logic [RW-1:0]         r_row;
   logic [CW-1:0]         r_col;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic [ADDR_WIDTH-1:0] r_mem_addr;

   // issue stage (address on the bus) and return stage (data on mem_rd_data_i)
   logic          r_iss_vld, r_iss_prod;
   logic [RW-1:0] r_iss_row;
   logic [CW-1:0] r_iss_col;
   logic          r_ret_vld, r_ret_prod;
   logic [RW-1:0] r_ret_row;
   logic [CW-1:0] r_ret_col;

   logic [2:0][2:0][DATA_WIDTH-1:0] r_win, w_win_nxt;
   logic [DATA_WIDTH-1:0]           w_lb0_q, w_lb1_q;

   fifo_entry_t r_fifo [2];
   logic        r_wr_ptr, r_rd_ptr;
   logic [1:0]  r_count;
   logic        r_done;

   logic                  w_issue, w_done_nxt, w_cur_prod;
   logic [RW-1:0]         w_cur_row;
   logic [CW-1:0]         w_cur_col;
   logic [ADDR_WIDTH-1:0] w_cur_addr;
   logic                  w_push, w_pop, w_credit_ok, w_drained, w_start_acc;
   logic [2:0]            w_pending;
   fifo_entry_t           w_push_entry;

   assign win_valid_o = (r_count != 2'd0);
   assign w_pop       = win_valid_o & win_ready_i;
   assign w_push      = r_ret_prod;
   assign w_start_acc = (r_state == ST_IDLE) & start_i;

   // An entry leaving this cycle frees its slot for the read being decided now.
   assign w_pending   = 3'(r_count) + 3'(r_iss_prod) + 3'(r_ret_prod) - 3'(w_pop);
   assign w_credit_ok = (w_pending < 3'd2);
   assign w_drained   = !r_iss_vld && !r_ret_vld &&
                        ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state, read issue decision and raster position of the read
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_done_nxt  = 1'b0;
      w_cur_row   = r_row;
      w_cur_col   = r_col;
      w_cur_addr  = r_next_addr;
      w_cur_prod  = (r_row >= RW'(2)) && (r_col >= CW'(2));
      case (r_state)
         ST_IDLE: begin
            // pixel (0,0) goes out on the start edge so index k lands in cycle 1+k
            if (start_i) begin
               w_issue     = 1'b1;
               w_cur_row   = '0;
               w_cur_col   = '0;
               w_cur_addr  = '0;
               w_cur_prod  = 1'b0;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!w_cur_prod || w_credit_ok) begin
               w_issue = 1'b1;
               if ((r_row == ROW_LAST) && (r_col == COL_LAST)) begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_drained) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // new window: shift left one column, right column is {lb1, lb0, returned pixel}
   always_comb begin
      w_win_nxt = r_win;
      for (int unsigned i = 0; i < 3; i++) begin
         w_win_nxt[i][0] = r_win[i][1];
         w_win_nxt[i][1] = r_win[i][2];
      end
      w_win_nxt[0][2] = w_lb1_q;
      w_win_nxt[1][2] = w_lb0_q;
      w_win_nxt[2][2] = mem_rd_data_i;
   end

   assign w_push_entry.win = w_win_nxt;
   assign w_push_entry.row = 16'(r_ret_row) - 16'd1;
   assign w_push_entry.col = 16'(r_ret_col) - 16'd1;

   // Line buffers are read from the issue-stage column so their registered
   // output lines up with the memory data in the return stage.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH)) u_lb0 (
      .clk_i     (clk_i),
      .wr_en_i   (r_ret_vld),
      .wr_addr_i (r_ret_col),
      .wr_data_i (mem_rd_data_i),
      .rd_addr_i (r_iss_col),
      .rd_data_o (w_lb0_q)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH)) u_lb1 (
      .clk_i     (clk_i),
      .wr_en_i   (r_ret_vld),
      .wr_addr_i (r_ret_col),
      .wr_data_i (w_lb0_q),
      .rd_addr_i (r_iss_col),
      .rd_data_o (w_lb1_q)
   );

   // raster counters, read pipeline, window register and done pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_row       <= '0;
         r_col       <= '0;
         r_next_addr <= '0;
         r_mem_addr  <= '0;
         r_iss_vld   <= 1'b0;
         r_iss_prod  <= 1'b0;
         r_iss_row   <= '0;
         r_iss_col   <= '0;
         r_ret_vld   <= 1'b0;
         r_ret_prod  <= 1'b0;
         r_ret_row   <= '0;
         r_ret_col   <= '0;
         r_win       <= '0;
         r_done      <= 1'b0;
      end else begin
         if (w_issue) begin
            r_mem_addr  <= w_cur_addr;
            r_next_addr <= w_cur_addr + 1'b1;
            r_iss_row   <= w_cur_row;
            r_iss_col   <= w_cur_col;
            if (w_cur_col == COL_LAST) begin
               r_col <= '0;
               r_row <= w_cur_row + 1'b1;
            end else begin
               r_col <= w_cur_col + 1'b1;
               r_row <= w_cur_row;
            end
         end
         r_iss_vld  <= w_issue;
         r_iss_prod <= w_issue & w_cur_prod;
         r_ret_vld  <= r_iss_vld;
         r_ret_prod <= r_iss_prod;
         r_ret_row  <= r_iss_row;
         r_ret_col  <= r_iss_col;
         if (r_ret_vld) begin
            r_win <= w_win_nxt;
         end
         r_done <= w_done_nxt;
      end
   end

   // 2-entry output FIFO; the credit check guarantees it never overflows
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_fifo[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign busy_o     = (r_state != ST_IDLE);
   assign done_o     = r_done;
   assign mem_addr_o = r_mem_addr;
   assign win_o      = r_fifo[r_rd_ptr].win;
   assign win_row_o  = r_fifo[r_rd_ptr].row;
   assign win_col_o  = r_fifo[r_rd_ptr].col;

`ifdef FETCH_PERF_EN
   logic [31:0] r_stall_cnt;

   // consumer back-pressure cycles within a frame, saturating
   always_ff @(posedge clk_i) begin
      if (rst_i || w_start_acc) begin
         r_stall_cnt <= '0;
      end else if (busy_o && win_valid_o && !win_ready_i && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cycles_o = r_stall_cnt;
`else
   logic w_unused_start_acc;
   assign w_unused_start_acc = w_start_acc;
`endif

endmodule

// File: tb/tb_mem_window_fetch.sv
// Directed self-checking bench for mem_window_fetch: 4x4, 3x3 and 8x8 ramp images.
module tb_mem_window_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        st4, busy4, done4, v4, rdy4;
   logic [15:0] addr4, row4, col4;
   logic [7:0]  rd4;
   logic [71:0] win4;

   logic        st3, busy3, done3, v3, rdy3;
   logic [15:0] addr3, row3, col3;
   logic [7:0]  rd3;
   logic [71:0] win3;

   logic        st8, busy8, done8, v8, rdy8;
   logic [15:0] addr8, row8, col8;
   logic [7:0]  rd8;
   logic [71:0] win8;

`ifdef FETCH_PERF_EN
   logic [31:0] stall4, stall3, stall8;
`endif

   int checks   = 0;
   int failures = 0;

   mem_window_fetch #(.IMG_W(4), .IMG_H(4), .ADDR_WIDTH(16), .DATA_WIDTH(8)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(st4), .busy_o(busy4), .done_o(done4),
      .mem_addr_o(addr4), .mem_rd_data_i(rd4), .win_valid_o(v4), .win_ready_i(rdy4),
      .win_o(win4), .win_row_o(row4),
`ifdef FETCH_PERF_EN
      .stall_cycles_o(stall4),
`endif
      .win_col_o(col4)
   );

   mem_window_fetch #(.IMG_W(3), .IMG_H(3), .ADDR_WIDTH(16), .DATA_WIDTH(8)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .start_i(st3), .busy_o(busy3), .done_o(done3),
      .mem_addr_o(addr3), .mem_rd_data_i(rd3), .win_valid_o(v3), .win_ready_i(rdy3),
      .win_o(win3), .win_row_o(row3),
`ifdef FETCH_PERF_EN
      .stall_cycles_o(stall3),
`endif
      .win_col_o(col3)
   );

   mem_window_fetch #(.IMG_W(8), .IMG_H(8), .ADDR_WIDTH(16), .DATA_WIDTH(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(st8), .busy_o(busy8), .done_o(done8),
      .mem_addr_o(addr8), .mem_rd_data_i(rd8), .win_valid_o(v8), .win_ready_i(rdy8),
      .win_o(win8), .win_row_o(row8),
`ifdef FETCH_PERF_EN
      .stall_cycles_o(stall8),
`endif
      .win_col_o(col8)
   );

   // ramp image memories: pixel value equals its linear index, one-cycle read latency
   always @(posedge clk) begin
      rd4 <= addr4[7:0];
      rd3 <= addr3[7:0];
      rd8 <= addr8[7:0];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected window of a ramp image of width w centred at (rc, cc)
   function automatic logic [71:0] exp_win(input int w, input int rc, input int cc);
      logic [71:0] e;
      e = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            e[(3*i+j)*8 +: 8] = 8'((rc - 1 + i) * w + (cc - 1 + j));
         end
      end
      return e;
   endfunction

   // one full 8x8 frame; optional extra start pulses and random ready
   task automatic run8(input int pa, input int pb, input bit rnd, input string tag);
      int n;
      int nd;
      n  = 0;
      nd = 0;
      st8 = 1'b1;
      @(posedge clk);
      #1;
      st8  = 1'b0;
      rdy8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int cyc = 1; cyc <= 4000 && nd == 0; cyc++) begin
         st8 = (cyc == pa) || (cyc == pb);
         if (v8) begin
            chk({tag, "_row"}, row8, 1 + n / 6);
            chk({tag, "_col"}, col8, 1 + n % 6);
            chk({tag, "_win"}, win8, exp_win(8, 1 + n / 6, 1 + n % 6));
            if (rdy8) n++;
         end
         if (done8) begin
            nd++;
            chk({tag, "_busy_at_done"}, busy8, 0);
         end
         step();
         rdy8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      st8  = 1'b0;
      rdy8 = 1'b1;
      chk({tag, "_win_count"}, n, 36);
      chk({tag, "_done_count"}, nd, 1);
      for (int cyc = 0; cyc < 8; cyc++) begin
         chk({tag, "_post_valid"}, v8, 0);
         chk({tag, "_post_busy"}, busy8, 0);
         chk({tag, "_post_done"}, done8, 0);
         step();
      end
   endtask

   int e_cyc [4] = '{13, 14, 17, 18};
   int e_row [4] = '{1, 1, 2, 2};
   int e_col [4] = '{1, 2, 1, 2};

   initial begin
      int nwin;
      int ndone;

      rst  = 1'b1;
      st4  = 1'b0; st3 = 1'b0; st8 = 1'b0;
      rdy4 = 1'b1; rdy3 = 1'b1; rdy8 = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();

      // reset state
      chk("rst_busy4", busy4, 0);
      chk("rst_done4", done4, 0);
      chk("rst_valid4", v4, 0);
      chk("rst_addr4", addr4, 0);
      chk("rst_win4", win4, 0);
      chk("rst_row4", row4, 0);
      chk("rst_col4", col4, 0);
      chk("rst_busy3", busy3, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_valid8", v8, 0);

      // 4x4 ramp, ready high: exact cycle timing
      nwin  = 0;
      ndone = 0;
      st4 = 1'b1;
      @(posedge clk);
      #1;
      st4 = 1'b0;
      for (int cyc = 1; cyc <= 22; cyc++) begin
         if (cyc <= 16) chk("t1_addr", addr4, cyc - 1);
         if (cyc == 1) chk("t1_busy_first", busy4, 1);
         if (cyc == 18) chk("t1_busy_last", busy4, 1);
         if (v4) begin
            if (nwin < 4) begin
               chk("t1_win_cycle", cyc, e_cyc[nwin]);
               chk("t1_row", row4, e_row[nwin]);
               chk("t1_col", col4, e_col[nwin]);
               chk("t1_win", win4, exp_win(4, e_row[nwin], e_col[nwin]));
            end
            nwin++;
         end
         if (done4) begin
            ndone++;
            chk("t1_done_cycle", cyc, 19);
            chk("t1_busy_at_done", busy4, 0);
         end
         step();
      end
      chk("t1_win_count", nwin, 4);
      chk("t1_done_count", ndone, 1);
      chk("t1_addr_hold", addr4, 15);

      // 3x3: single window
      nwin  = 0;
      ndone = 0;
      st3 = 1'b1;
      @(posedge clk);
      #1;
      st3 = 1'b0;
      for (int cyc = 1; cyc <= 15; cyc++) begin
         if (v3) begin
            chk("t2_win_cycle", cyc, 11);
            chk("t2_row", row3, 1);
            chk("t2_col", col3, 1);
            chk("t2_win", win3, 72'h08_07_06_05_04_03_02_01_00);
            nwin++;
         end
         if (done3) begin
            ndone++;
            chk("t2_done_cycle", cyc, 12);
         end
         step();
      end
      chk("t2_win_count", nwin, 1);
      chk("t2_done_count", ndone, 1);

      // 8x8, random ready: order, content and stability while stalled
      run8(0, 0, 1'b1, "t3");

      // 8x8 with start pulsed mid-frame
      run8(20, 40, 1'b0, "t4");

      // reset in cycle 10 of an 8x8 frame, then a clean frame
      st8 = 1'b1;
      @(posedge clk);
      #1;
      st8 = 1'b0;
      repeat (9) step();
      chk("t5_busy_c10", busy8, 1);
      chk("t5_addr_c10", addr8, 9);
      rst = 1'b1;
      step();
      chk("t5_busy", busy8, 0);
      chk("t5_done", done8, 0);
      chk("t5_valid", v8, 0);
      chk("t5_addr", addr8, 0);
      chk("t5_win", win8, 0);
      chk("t5_row", row8, 0);
      chk("t5_col", col8, 0);
      rst = 1'b0;
      step();
      run8(0, 0, 1'b0, "t5");

`ifdef FETCH_PERF_EN
      begin
         int  lowcnt;
         bit  started;
         ndone   = 0;
         lowcnt  = 0;
         started = 1'b0;
         st4 = 1'b1;
         @(posedge clk);
         #1;
         st4 = 1'b0;
         for (int cyc = 1; cyc <= 200 && ndone == 0; cyc++) begin
            if (!started && v4) begin
               started = 1'b1;
               lowcnt  = 5;
            end
            rdy4 = (lowcnt != 0) ? 1'b0 : 1'b1;
            if (lowcnt != 0) lowcnt--;
            if (done4) begin
               ndone++;
               chk("perf_stall_cycles", stall4, 5);
            end
            step();
         end
         rdy4 = 1'b1;
         chk("perf_done_count", ndone, 1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_window_fetch.md
# mem_window_fetch

Reads a stored image out of the single-port image memory in raster order and streams every interior 3x3 pixel neighbourhood to the Sobel core.
- Sits directly downstream of the image memory and upstream of the Sobel core.
- Owns the memory read address and the line buffers.
- Exposes a valid/ready window stream with the centre-pixel coordinates.

## Interface
- IMG_W, default from sobel_config_pkg (256): image width in pixels, ≥ 3.
- IMG_H, default from sobel_config_pkg (256): image height in pixels, ≥ 3.
- ADDR_WIDTH, default from mem_config_pkg: memory address width; IMG_W*IMG_H ≤ 2**ADDR_WIDTH.
- DATA_WIDTH, default from mem_config_pkg (8): pixel width.
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle frame start; ignored while busy_o = 1.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse after the last window is accepted.
- mem_addr_o  out  ADDR_WIDTH  registered read address to the image memory; pixel (r,c) is at r*IMG_W + c.
- mem_rd_data_i  in  DATA_WIDTH  memory read data, valid 1 cycle after the address.
- win_valid_o  out  1  window output valid.
- win_ready_i  in  1  consumer accepts the window; the transfer happens on valid && ready.
- win_o  out  9*DATA_WIDTH  packed window; slice 3*i+j is pixel (row_c-1+i, col_c-1+j). Slice 0 is top-left, 4 is the centre, 8 is bottom-right.
- win_row_o / win_col_o  out  16 each  centre coordinates (row_c, col_c).

## Operation
- The FSM has three states: IDLE, FETCH and DRAIN.
- IDLE → FETCH on start_i. The raster counters (r,c) are cleared.
- FETCH issues one read per cycle, index k = 0 .. IMG_W*IMG_H-1, when a credit is available.
- FETCH → DRAIN after the last index has been issued.
- DRAIN → IDLE once no read is in flight and the output buffer is empty. done_o pulses on that transition.
- Window formation on a returned pixel p at (r,c):
  - The 3x3 register shifts left by one column.
  - The new right column is {lb1[c], lb0[c], p}.
  - Line buffers update: lb1[c] ← lb0[c], lb0[c] ← p.
  - lb0/lb1 are read at issue time with 1-cycle latency, so their data aligns with mem_rd_data_i.
- A window is produced only when r ≥ 2 and c ≥ 2. Its centre is (r-1, c-1).
- Window count per frame is (IMG_W-2)*(IMG_H-2). Border pixels produce no windows.
- The output buffer is a 2-entry FIFO. Credit rule: a window-producing read issues only if FIFO occupancy plus window-producing reads in flight is < 2. Non-producing reads always issue.
- No window is ever dropped or duplicated under any win_ready_i pattern.
- start_i while busy is ignored, with no side effects.
- rst_i mid-frame aborts the frame:
  - FSM returns to IDLE; FIFO and in-flight reads are discarded.
  - No done_o is generated.
  - Line buffer contents are don't-care.
- Reset values: busy_o, done_o, win_valid_o = 0; mem_addr_o, win_o, win_row_o, win_col_o = 0.

## Timing
- start_i sampled at cycle 0. Index k is issued on mem_addr_o in cycle 1+k and returns in cycle 2+k.
- Its window (if any) gives win_valid_o = 1 in cycle 3+k. With win_ready_i held high there are no bubbles.
- The first window appears in cycle 2*IMG_W+5.
- With ready always high, done_o pulses in cycle IMG_W*IMG_H+3.
- busy_o is 1 from cycle 1 up to the cycle before done_o, and 0 during the done_o cycle.
- While win_valid_o = 1 and win_ready_i = 0, win_o / win_row_o / win_col_o hold stable.
- mem_addr_o holds its last value while stalled and in IDLE.

## Configuration
- FETCH_PERF_EN defined:
  - Adds output stall_cycles_o (32 bits).
  - It counts cycles with busy_o && win_valid_o && !win_ready_i, saturating at 2**32-1.
  - It is cleared on an accepted start_i and held after done_o.
- FETCH_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- sobel_config_pkg holds IMG_W, IMG_H, the window typedef (3x3 array of pixel_t) and the fsm state enum.
- mem_config_pkg holds ADDR_WIDTH and DATA_WIDTH.
- One sub-module, line_buffer: simple dual-port RAM, depth IMG_W, 1-cycle registered read, write-first not required. It is instantiated twice (lb0, lb1).
- The credit counter, the 2-entry FIFO and the FSM stay in mem_window_fetch.

## Test plan
- 4x4 ramp image (pixel = index), ready high. Expected:
  - 4 windows at cycles 13, 14, 17, 18.
  - The first is centre (1,1) with slices 0,1,2,4,5,6,8,9,10.
  - done_o in cycle 19.
- 3x3 image: exactly one window, centre (1,1); done_o in cycle 12.
- 8x8 ramp with random win_ready_i (50%): all 36 windows arrive in raster order with correct contents, and win_o is stable while stalled.
- start_i pulsed again mid-frame: no restart, window count unchanged, a single done_o.
- rst_i asserted in cycle 10 of an 8x8 frame:
  - Cycle 11: all outputs are 0 and busy_o is 0.
  - A new start_i then yields a correct full frame.
- FETCH_PERF_EN build: win_ready_i held low for 5 cycles once valid is up gives stall_cycles_o = 5 at done_o.
